// File: rtl/ledarbiter_pkg.sv
// ledarbiter_pkg: shared state encoding and control word bit positions
package ledarbiter_pkg;
  typedef enum logic {AUTO = 1'b0, MANUAL = 1'b1} state_t;
  localparam int PIN_BIT = 31;
  localparam int RELEASE_BIT = 30;
  localparam int MASK_LSB = 16;
  localparam int VALUE_LSB = 0;
endpackage

// File: rtl/ledarbiter_ledtimeout.sv
// ledtimeout: reloadable down-counter that pulses once when an armed count reaches zero
module ledtimeout #(
  parameter int TIMEOUT = 100000000,
  parameter int CTRBITS = 27
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);
  logic [CTRBITS-1:0] count;
  logic armed;
  always_comb o_expired = i_en && armed && count == '0;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      count <= '0;
      armed <= 1'b0;
    end else begin
      count <= i_load ? CTRBITS'(TIMEOUT - 1) : (i_en && count != '0) ? count - CTRBITS'(1) : count;
      armed <= i_load || (armed && !o_expired);
    end
endmodule

// File: rtl/ledarbiter.sv
// ledarbiter: arbitrates LED pins between bouncer animation and software-owned values with idle timeout
module ledarbiter
  import ledarbiter_pkg::*;
#(
  parameter int NLEDS = 8,
  parameter int TIMEOUT = 100000000,
  parameter int CTRBITS = 27
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NLEDS-1:0] i_bounce,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic [NLEDS-1:0] o_led
);
  state_t state;
  logic [NLEDS-1:0] owned, swval, mask, value, owned_n, swval_n;
  logic [31:0] rd;
  logic pinned, stb, wr, rel, act, drop, expired, unused_ok;
  assign o_wb_stall = 1'b0;
  assign unused_ok = &{1'b0, i_wb_data};
  always_comb begin
    stb = i_wb_cyc && i_wb_stb;
    wr = stb && i_wb_we && i_wb_sel == 4'hf;
    mask = i_wb_data[MASK_LSB +: NLEDS];
    value = i_wb_data[VALUE_LSB +: NLEDS];
    rel = wr && i_wb_data[RELEASE_BIT];
    act = wr && !i_wb_data[RELEASE_BIT] && (state == MANUAL || |mask);
    drop = expired && !pinned && !act;
    owned_n = (rel || drop) ? '0 : act ? owned | mask : owned;
    swval_n = act ? (swval & ~mask) | (value & mask) : swval;
    rd = '0;
    rd[PIN_BIT] = pinned;
    rd[RELEASE_BIT] = state == MANUAL;
    rd[MASK_LSB +: NLEDS] = owned;
    rd[VALUE_LSB +: NLEDS] = o_led;
  end
  ledtimeout #(.TIMEOUT(TIMEOUT), .CTRBITS(CTRBITS)) u_timeout (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_load(act),
    .i_en(state == MANUAL),
    .o_expired(expired)
  );
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state <= AUTO;
      owned <= '0;
      swval <= '0;
      pinned <= 1'b0;
      o_led <= '0;
      o_wb_ack <= 1'b0;
      o_wb_data <= '0;
    end else begin
      state <= (rel || drop) ? AUTO : act ? MANUAL : state;
      owned <= owned_n;
      swval <= swval_n;
      pinned <= rel ? 1'b0 : act ? pinned | i_wb_data[PIN_BIT] : pinned;
      o_led <= (owned_n & swval_n) | (~owned_n & i_bounce);
      o_wb_ack <= stb;
      o_wb_data <= stb ? rd : o_wb_data;
    end
endmodule

// File: tb/tb_ledarbiter.sv
// tb_ledarbiter: directed and random checks of ledarbiter against a deadline-based behavioural model
module tb_ledarbiter;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst = 0, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] dat = 0;
  logic [7:0] bounce = 0;
  logic stall, ack;
  logic [31:0] rdata;
  logic [7:0] led;
  int passed = 0, total = 0;

  ledarbiter #(.NLEDS(8), .TIMEOUT(TIMEOUT), .CTRBITS(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_bounce(bounce),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_data(dat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata), .o_led(led)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  int unsigned n = 0, lastw = 0;
  logic [7:0] m_owned = 0, m_swval = 0, m_led = 0, mk;
  logic m_pin = 0, m_man = 0, m_ack = 0;
  logic [31:0] m_data = 0, m_rd;
  bit mvalid = 0, s, w, rel, act, expire;

  always @(posedge clk) begin
    n++;
    if (rst) begin
      m_owned = 0; m_swval = 0; m_led = 0; m_pin = 0; m_man = 0; m_ack = 0; m_data = 0;
      mvalid = 1;
    end else begin
      s = cyc && stb;
      w = s && we && sel == 4'hf;
      mk = dat[23:16];
      rel = w && dat[30];
      act = w && !dat[30] && (m_man || mk != 0);
      expire = m_man && !m_pin && n == lastw + TIMEOUT;
      m_rd = {m_pin, m_man, 6'b0, m_owned, 8'b0, m_led};
      if (rel) begin
        m_owned = 0; m_pin = 0; m_man = 0;
      end else if (act) begin
        m_swval = (m_swval & ~mk) | (dat[7:0] & mk);
        m_owned = m_owned | mk;
        m_pin = m_pin | dat[31];
        m_man = 1;
        lastw = n;
      end else if (expire) begin
        m_owned = 0; m_man = 0;
      end
      m_led = (m_owned & m_swval) | (~m_owned & bounce);
      if (s) m_data = m_rd;
      m_ack = s;
    end
  end

  always @(negedge clk)
    if (mvalid) begin
      check("ack", {31'b0, ack}, {31'b0, m_ack});
      check("rdata", rdata, m_data);
      check("led", {24'b0, led}, {24'b0, m_led});
      check("stall", {31'b0, stall}, 32'b0);
    end

  task automatic step(input logic r, input logic c, input logic st, input logic w_,
                      input logic [3:0] se, input logic [31:0] d, input logic [7:0] b);
    rst = r; cyc = c; stb = st; we = w_; sel = se; dat = d; bounce = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] d);
    step(0, 1, 1, 1, 4'hf, d, 8'h5a);
  endtask

  task automatic rd();
    step(0, 1, 1, 0, 4'hf, 32'h0, 8'h5a);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 4'h0, 32'h0, 8'h5a);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 4'h0, 32'h0, 8'h00);
    check("reset_led", {24'b0, led}, 32'h0);
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_data", rdata, 32'h0);
    idle(1);
    check("bounce_pass", {24'b0, led}, 32'h5a);
    rd();
    check("rd_idle", rdata, 32'h0000_005a);
    wr(32'h000f_0003);
    check("wr_ack", {31'b0, ack}, 32'h1);
    check("wr_led", {24'b0, led}, 32'h53);
    check("model_led", {24'b0, m_led}, 32'h53);
    rd();
    check("rd_manual", rdata, 32'h400f_0053);
    idle(14);
    check("before_timeout", {24'b0, led}, 32'h53);
    idle(1);
    check("after_timeout", {24'b0, led}, 32'h5a);
    rd();
    check("rd_released", rdata, 32'h0000_005a);
    wr(32'h8001_0001);
    idle(100);
    check("pinned_led", {24'b0, led}, 32'h5b);
    rd();
    check("rd_pinned", rdata, 32'hc001_005b);
    wr(32'h4000_0000);
    check("release_led", {24'b0, led}, 32'h5a);
    rd();
    check("rd_release", rdata, 32'h0000_005a);
    step(0, 1, 1, 1, 4'h3, 32'h00ff_00aa, 8'h5a);
    check("badsel_ack", {31'b0, ack}, 32'h1);
    check("badsel_led", {24'b0, led}, 32'h5a);
    rd();
    check("rd_badsel", rdata, 32'h0000_005a);
    wr(32'h0001_0001);
    idle(15);
    wr(32'h0002_0002);
    check("collide_led", {24'b0, led}, 32'h5b);
    idle(15);
    check("reload_hold", {24'b0, led}, 32'h5b);
    idle(1);
    check("reload_expire", {24'b0, led}, 32'h5a);
    wr(32'h00ff_00ff);
    step(1, 1, 1, 0, 4'hf, 32'h0, 8'h5a);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_led", {24'b0, led}, 32'h0);
    check("rst_data", rdata, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      d = $urandom;
      d[31] = $urandom_range(0, 7) == 0;
      d[30] = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 2) == 0) d[23:16] = 8'h00;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'hf,
           d, 8'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
